// File: rtl/mem_access_unit_if.sv
// Memory-side bus of the MAR/MDR access unit: address, write data,
// request/write strobes and the memory's read data and ready response.
interface mem_access_unit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) ();
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    // The access unit drives address, data and strobes toward memory
    modport master (
        output mar, mdr, mem_req, mem_we,
        input  mem_rdata, mem_ready
    );

    // The memory model answers with read data and ready
    modport slave (
        input  mar, mdr, mem_req, mem_we,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_access_unit.sv
// LC-3 MAR/MDR memory access unit: holds MAR and MDR, runs a request/ready
// handshake to variable-latency memory, pulses R on completion, flags MDR
// changes and aborts accesses that wait too long for the memory.
module mem_access_unit #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              ld_mar,
    input  logic              ld_mdr,
    input  logic              mio_en,
    input  logic              r_w,
    input  logic              err_clr,
    mem_access_unit_if.master mem,
    output logic              r,
    output logic              mdr_change,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The wait counter only has to reach TIMEOUT_CYC-1
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic              mio_q;
    logic              chg_q;
    logic              err_q, err_d;
    logic              timeout_hit;

    // Next-state and register-load decisions; loads are only honoured in IDLE
    // so the address and data stay stable while memory works on them
    always_comb begin
        state_d     = state_q;
        mar_d       = mar_q;
        mdr_d       = mdr_q;
        rw_d        = rw_q;
        cnt_d       = cnt_q;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_mar) mar_d = bus_in[ADDR_W-1:0];
                if (ld_mdr) mdr_d = bus_in;
                if (mio_en && !mio_q) begin
                    state_d = REQ;
                    rw_d    = r_w;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                if (mem.mem_ready) begin
                    state_d = DONE;
                    if (!rw_q) mdr_d = mem.mem_rdata;
                end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST)) begin
                    state_d     = IDLE;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A timeout in the same cycle as a clear request keeps the flag set
        if (timeout_hit)  err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
        else              err_d = err_q;
    end

    // State, datapath registers, edge detector and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            mio_q   <= 1'b0;
            chg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            mio_q   <= mio_en;
            chg_q   <= (mdr_d != mdr_q);
            err_q   <= err_d;
        end
    end

    // Outputs decode straight from the state register so a reset drops them at once
    always_comb begin
        mem.mar     = mar_q;
        mem.mdr     = mdr_q;
        mem.mem_req = (state_q == REQ);
        mem.mem_we  = (state_q == REQ) && rw_q;
        r           = (state_q == DONE);
        busy        = (state_q != IDLE);
        mdr_change  = chg_q;
        timeout_err = err_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against an
// access-level behavioural model.
module tb_mem_access_unit;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 16;
    localparam int TIMEOUT_CYC = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] bus_in;
    logic              ld_mar, ld_mdr, mio_en, r_w, err_clr;
    logic              r, mdr_change, busy, timeout_err;

    mem_access_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem ();

    mem_access_unit #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_in),
        .ld_mar(ld_mar), .ld_mdr(ld_mdr), .mio_en(mio_en), .r_w(r_w),
        .err_clr(err_clr), .mem(mem.master),
        .r(r), .mdr_change(mdr_change), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: an access is "outstanding" for a number of request
    // cycles; it either completes (then one R cycle) or is abandoned after
    // TIMEOUT_CYC request cycles.
    logic [ADDR_W-1:0] m_mar = '0;
    logic [DATA_W-1:0] m_mdr = '0;
    logic [DATA_W-1:0] m_prev_mdr;
    int                m_req_age = 0;
    bit                m_r = 0, m_we = 0, m_prev_mio = 0, m_change = 0, m_err = 0;
    bit                m_set_err;

    // Advance the model one clock using the inputs the DUT also sees
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mar = '0; m_mdr = '0; m_req_age = 0; m_r = 0; m_we = 0;
            m_prev_mio = 0; m_change = 0; m_err = 0;
        end else begin
            m_prev_mdr = m_mdr;
            m_set_err  = 0;
            if (m_r) begin
                m_r = 0;
            end else if (m_req_age > 0) begin
                if (mem.mem_ready) begin
                    if (!m_we) m_mdr = mem.mem_rdata;
                    m_r       = 1;
                    m_req_age = 0;
                end else if (TIMEOUT_CYC != 0 && m_req_age == TIMEOUT_CYC) begin
                    m_req_age = 0;
                    m_set_err = 1;
                end else begin
                    m_req_age++;
                end
            end else begin
                if (ld_mar) m_mar = bus_in[ADDR_W-1:0];
                if (ld_mdr) m_mdr = bus_in;
                if (mio_en && !m_prev_mio) begin
                    m_req_age = 1;
                    m_we      = r_w;
                end
            end
            m_change   = (m_mdr != m_prev_mdr);
            m_err      = m_set_err | (m_err & ~err_clr);
            m_prev_mio = mio_en;
        end
    end

    // Tallies of what memory and the control FSM observed
    int                req_cycles = 0, we_cycles = 0, r_pulses = 0, chg_pulses = 0, accesses = 0;
    logic [ADDR_W-1:0] req_addr  = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    bit                prev_req  = 0;

    // Compare every output against the model on the falling edge
    always @(negedge clk) begin
        checkOutput("mar",         mem.mar,     m_mar);
        checkOutput("mdr",         mem.mdr,     m_mdr);
        checkOutput("mem_req",     mem.mem_req, m_req_age > 0);
        checkOutput("mem_we",      mem.mem_we,  (m_req_age > 0) && m_we);
        checkOutput("r",           r,           m_r);
        checkOutput("mdr_change",  mdr_change,  m_change);
        checkOutput("busy",        busy,        (m_req_age > 0) || m_r);
        checkOutput("timeout_err", timeout_err, m_err);
        if (mem.mem_req) begin
            req_cycles++;
            req_addr  = mem.mar;
            req_wdata = mem.mdr;
            if (!prev_req) accesses++;
        end
        prev_req = mem.mem_req;
        if (mem.mem_we)  we_cycles++;
        if (r)           r_pulses++;
        if (mdr_change)  chg_pulses++;
    end

    int b_req, b_we, b_r, b_chg, b_acc;

    task automatic snap();
        b_req = req_cycles; b_we = we_cycles; b_r = r_pulses;
        b_chg = chg_pulses; b_acc = accesses;
    endtask

    // Drive one cycle's inputs just after the next rising edge
    task automatic applyStimulus(input logic [DATA_W-1:0] bus, input bit lm, input bit lmd,
                                 input bit mio, input bit rw, input bit clr, input bit rdy,
                                 input logic [DATA_W-1:0] rdata);
        @(posedge clk);
        #2;
        bus_in = bus; ld_mar = lm; ld_mdr = lmd; mio_en = mio; r_w = rw;
        err_clr = clr; mem.mem_ready = rdy; mem.mem_rdata = rdata;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus('0, 0, 0, 0, 0, 0, 0, '0);
    endtask

    initial begin
        rst_n = 1'b1;
        bus_in = '0; ld_mar = 0; ld_mdr = 0; mio_en = 0; r_w = 0; err_clr = 0;
        mem.mem_ready = 0; mem.mem_rdata = '0;
        #1 rst_n = 1'b0;
        #11;
        checkOutput("reset_mar",  mem.mar,     16'h0);
        checkOutput("reset_mdr",  mem.mdr,     16'h0);
        checkOutput("reset_req",  mem.mem_req, 1'b0);
        checkOutput("reset_busy", busy,        1'b0);
        checkOutput("reset_err",  timeout_err, 1'b0);
        @(posedge clk); #2 rst_n = 1'b1;

        // Read with three request cycles
        $display("[TB] read 0x3000 with 3-cycle latency");
        snap();
        applyStimulus(16'h3000, 1, 0, 0, 0, 0, 0, '0);
        applyStimulus('0, 0, 0, 1, 0, 0, 0, '0);
        applyStimulus('0, 0, 0, 1, 0, 0, 0, '0);
        applyStimulus('0, 0, 0, 1, 0, 0, 0, '0);
        applyStimulus('0, 0, 0, 1, 0, 0, 1, 16'hBEEF);
        idleCycles(4);
        checkOutput("rd_mdr",      mem.mdr,            16'hBEEF);
        checkOutput("rd_req_cyc",  req_cycles - b_req, 3);
        checkOutput("rd_addr",     req_addr,           16'h3000);
        checkOutput("rd_r",        r_pulses - b_r,     1);
        checkOutput("rd_chg",      chg_pulses - b_chg, 1);
        checkOutput("rd_busy",     busy,               1'b0);
        checkOutput("rd_we",       we_cycles - b_we,   0);

        // Write with ready in the first request cycle
        $display("[TB] write 0x1234 to 0x4000");
        applyStimulus(16'h1234, 0, 1, 0, 0, 0, 0, '0);
        applyStimulus(16'h4000, 1, 0, 0, 0, 0, 0, '0);
        snap();
        applyStimulus('0, 0, 0, 1, 1, 0, 1, 16'h5A5A);
        applyStimulus('0, 0, 0, 1, 1, 0, 1, 16'h5A5A);
        idleCycles(4);
        checkOutput("wr_we_cyc",  we_cycles - b_we,   1);
        checkOutput("wr_req_cyc", req_cycles - b_req, 1);
        checkOutput("wr_addr",    req_addr,           16'h4000);
        checkOutput("wr_wdata",   req_wdata,          16'h1234);
        checkOutput("wr_r",       r_pulses - b_r,     1);
        checkOutput("wr_mdr",     mem.mdr,            16'h1234);

        // Read returning the value already in MDR
        $display("[TB] read of equal value");
        snap();
        applyStimulus('0, 0, 0, 1, 0, 0, 0, '0);
        applyStimulus('0, 0, 0, 1, 0, 0, 1, 16'h1234);
        idleCycles(4);
        checkOutput("eq_r",   r_pulses - b_r,     1);
        checkOutput("eq_chg", chg_pulses - b_chg, 0);
        checkOutput("eq_mdr", mem.mdr,            16'h1234);

        // Memory never answers
        $display("[TB] timeout");
        snap();
        applyStimulus('0, 0, 0, 1, 0, 0, 0, '0);
        for (int i = 0; i < 20; i++) applyStimulus('0, 0, 0, 1, 0, 0, 0, 16'hFFFF);
        checkOutput("to_req_cyc", req_cycles - b_req, TIMEOUT_CYC);
        checkOutput("to_err",     timeout_err,        1'b1);
        checkOutput("to_r",       r_pulses - b_r,     0);
        checkOutput("to_mdr",     mem.mdr,            16'h1234);
        checkOutput("to_busy",    busy,               1'b0);
        applyStimulus('0, 0, 0, 0, 0, 1, 0, '0);
        idleCycles(2);
        checkOutput("to_clr", timeout_err, 1'b0);

        // mio_en held high, loads attempted during the request
        $display("[TB] held request with ignored loads");
        snap();
        applyStimulus('0, 0, 0, 1, 1, 0, 0, '0);
        applyStimulus(16'hFFFF, 1, 1, 1, 1, 0, 0, '0);
        applyStimulus(16'hFFFF, 1, 1, 1, 1, 0, 0, '0);
        applyStimulus('0, 0, 0, 1, 1, 0, 1, '0);
        for (int i = 0; i < 6; i++) applyStimulus('0, 0, 0, 1, 1, 0, 1, '0);
        checkOutput("hold_acc", accesses - b_acc, 1);
        checkOutput("hold_r",   r_pulses - b_r,   1);
        checkOutput("hold_mar", mem.mar,          16'h4000);
        checkOutput("hold_mdr", mem.mdr,          16'h1234);
        idleCycles(2);

        // Reset in the middle of a request
        $display("[TB] reset during request");
        applyStimulus('0, 0, 0, 1, 0, 0, 0, '0);
        applyStimulus('0, 0, 0, 1, 0, 0, 0, '0);
        @(posedge clk);
        #2;
        checkOutput("rst_pre_req", mem.mem_req, 1'b1);
        rst_n = 1'b0;
        mio_en = 0;
        #1;
        checkOutput("rst_req",  mem.mem_req, 1'b0);
        checkOutput("rst_mar",  mem.mar,     16'h0);
        checkOutput("rst_mdr",  mem.mdr,     16'h0);
        checkOutput("rst_busy", busy,        1'b0);
        @(posedge clk); #2 rst_n = 1'b1;
        applyStimulus(16'h5555, 1, 0, 0, 0, 0, 0, '0);
        applyStimulus('0, 0, 0, 1, 0, 0, 0, '0);
        applyStimulus('0, 0, 0, 1, 0, 0, 1, 16'hCAFE);
        idleCycles(3);
        checkOutput("post_rst_mdr", mem.mdr, 16'hCAFE);
        checkOutput("post_rst_mar", mem.mar, 16'h5555);

        // Randomized traffic, model-checked every cycle
        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            int          mode;
            bit          rdy;
            logic [15:0] bus, rdata;
            mode  = (i / 250) % 3;
            rdy   = (mode == 0) ? ($urandom_range(0, 1) == 0)
                  : (mode == 1) ? ($urandom_range(0, 7) == 0)
                  :               ($urandom_range(0, 31) == 0);
            bus   = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            rdata = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            applyStimulus(bus, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                          ($urandom_range(0, 2) == 0) ? ~mio_en : mio_en,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, rdy, rdata);
            if (!rst_n)                          rst_n = 1'b1;
            else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
        end
        rst_n = 1'b1;
        idleCycles(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
